// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, next-PC select and fetch control.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned redirect).
module pc_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int ROM_SIZE = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_target_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  instr_valid_o,
  output logic                  halted_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o,
  output logic [31:0]           retired_count_o
);

  localparam logic [ADDR_WIDTH-1:0] PC_LIMIT =
    ADDR_WIDTH'(ROM_SIZE * 4);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    halted_q, halted_d;
  logic                    trap_q, trap_d;
  logic [1:0]              cause_q, cause_d;
  logic [31:0]             count_q, count_d;

  logic                    redirect;
  logic [ADDR_WIDTH-1:0]   redir_raw;
  logic [ADDR_WIDTH-1:0]   redir_tgt;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic                    misalign;
  logic                    cur_ok;
  logic                    next_ok;
  logic                    is_ebreak;

  assign redirect  = jump_i | branch_taken_i;
  assign redir_raw = jump_i ? jump_target_i : branch_target_i;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt = redir_raw;
  assign misalign  = redirect & (|redir_raw[1:0]);
`else
  assign redir_tgt = redir_raw & ALIGN_MASK;
  assign misalign  = 1'b0;
`endif

  assign pc_plus4_o = pc_q + FOUR;
  assign next_pc    = redirect ? redir_tgt : pc_plus4_o;
  assign cur_ok     = pc_q < PC_LIMIT;
  assign next_ok    = next_pc < PC_LIMIT;
  assign is_ebreak  = instruction_i == EBREAK;

  assign pc_o            = pc_q;
  assign instr_valid_o   = (state_q == RUN) && cur_ok;
  assign instruction_o   = instr_valid_o ? instruction_i : NOP;
  assign halted_o        = halted_q;
  assign trap_o          = trap_q;
  assign trap_cause_o    = cause_q;
  assign retired_count_o = count_q;

  // State register and all architectural fetch state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= 2'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
    end
  end

  // Next state: PC advance, halt detection and retire accounting.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    count_d  = count_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall_i) begin
          if (!cur_ok) begin
            state_d  = HALT;
            halted_d = 1'b1;
            trap_d   = 1'b1;
            cause_d  = 2'd2;
          end else if (is_ebreak) begin
            state_d  = HALT;
            halted_d = 1'b1;
            trap_d   = 1'b0;
            cause_d  = 2'd3;
          end else if (!next_ok) begin
            state_d  = HALT;
            halted_d = 1'b1;
            trap_d   = 1'b1;
            cause_d  = 2'd2;
            count_d  = count_q + 32'd1;
          end else if (misalign) begin
            state_d  = HALT;
            halted_d = 1'b1;
            trap_d   = 1'b1;
            cause_d  = 2'd1;
            count_d  = count_q + 32'd1;
          end else begin
            pc_d    = next_pc;
            count_d = count_q + 32'd1;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scenario tasks with a per-cycle expectation queue.
// Honours FETCH_MISALIGN_TRAP_EN when building expectations.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [3:0]  S_OK  = 4'b0000;
  localparam logic [3:0]  S_EBK = 4'b1011;
  localparam logic [3:0]  S_OOR = 4'b1110;
  localparam logic [3:0]  S_MIS = 4'b1101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic        jp = 1'b0;
  logic [31:0] bt = '0;
  logic [31:0] jt = '0;
  logic [31:0] instr;
  logic [31:0] pc, pc4, instr_o, cnt;
  logic        valid, halted, trap;
  logic [1:0]  cause;
  logic        eb_en = 1'b0;
  logic [31:0] eb_pc = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        st;
    logic        b;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [3:0]  s;
    logic [31:0] n;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always_comb begin
    instr = {pc[11:0], 20'h00013};
    if (eb_en && pc == eb_pc) instr = EBRK;
  end

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(bt),
    .jump_i(jp), .jump_target_i(jt),
    .instruction_i(instr), .pc_o(pc), .pc_plus4_o(pc4),
    .instruction_o(instr_o), .instr_valid_o(valid),
    .halted_o(halted), .trap_o(trap), .trap_cause_o(cause),
    .retired_count_o(cnt)
  );

  function automatic stim_t S(input logic s, input logic b,
      input logic [31:0] b_t, input logic j, input logic [31:0] j_t);
    S = '{st: s, b: b, bt: b_t, j: j, jt: j_t};
  endfunction

  function automatic exp_t E(input logic [31:0] p, input logic v,
      input logic [3:0] s, input logic [31:0] n);
    E = '{pc: p, v: v, s: s, n: n};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t s);
    stall = s.st; br = s.b; bt = s.bt; jp = s.j; jt = s.jt;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    eb_en = 1'b0;
    apply(S(0, 0, 0, 0, 0));
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    rst = 1'b1;
    apply(S(1, 1, 32'h10, 1, 32'h40));
    sb.push_back(E(32'h0, 1'b0, S_OK, 32'd0));
    tick;
    e = sb.pop_front();
    checks += 5;
    if (pc !== e.pc) begin failures++;
      $display("FAIL reset pc: got %h want %h", pc, e.pc); end
    if (valid !== e.v) begin failures++;
      $display("FAIL reset valid: got %b want %b", valid, e.v); end
    if ({halted, trap, cause} !== e.s) begin failures++;
      $display("FAIL reset status: got %b want %b", {halted, trap, cause}, e.s); end
    if (cnt !== e.n) begin failures++;
      $display("FAIL reset count: got %0d want %0d", cnt, e.n); end
    if (instr_o !== NOP) begin failures++;
      $display("FAIL reset instr: got %h want %h", instr_o, NOP); end
    rst = 1'b0;
    apply(S(0, 0, 0, 0, 0));
  endtask

  task automatic test_sequential;
    stim_t st[4];
    exp_t ex[4];
    exp_t e;
    logic [31:0] wi;
    do_reset;
    checks++;
    if (valid !== 1'b0 || pc !== 32'h0) begin failures++;
      $display("FAIL seq boot: got pc=%h v=%b want pc=0 v=0", pc, valid); end
    for (int i = 0; i < 4; i++) begin
      st[i] = S(0, 0, 0, 0, 0);
      ex[i] = E(32'(i * 4), 1'b1, S_OK, 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick;
      e = sb.pop_front();
      wi = e.v ? {e.pc[11:0], 20'h00013} : NOP;
      checks += 5;
      if (pc !== e.pc) begin failures++;
        $display("FAIL seq pc[%0d]: got %h want %h", i, pc, e.pc); end
      if (valid !== e.v) begin failures++;
        $display("FAIL seq valid[%0d]: got %b want %b", i, valid, e.v); end
      if ({halted, trap, cause} !== e.s) begin failures++;
        $display("FAIL seq status[%0d]: got %b want %b", i, {halted, trap, cause}, e.s); end
      if (cnt !== e.n) begin failures++;
        $display("FAIL seq count[%0d]: got %0d want %0d", i, cnt, e.n); end
      if (instr_o !== wi) begin failures++;
        $display("FAIL seq instr[%0d]: got %h want %h", i, instr_o, wi); end
    end
  endtask

  task automatic test_jump_priority;
    stim_t st[4];
    exp_t ex[4];
    exp_t e;
    do_reset;
    st = '{S(0, 0, 0, 0, 0), S(0, 0, 0, 0, 0), S(0, 0, 0, 0, 0),
           S(0, 1, 32'h20, 1, 32'h40)};
    ex = '{E(32'h0, 1, S_OK, 0), E(32'h4, 1, S_OK, 1),
           E(32'h8, 1, S_OK, 2), E(32'h40, 1, S_OK, 3)};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      if (i == 3) begin
        checks++;
        if (pc4 !== 32'hC) begin failures++;
          $display("FAIL jprio pc4@8: got %h want %h", pc4, 32'hC); end
      end
      sb.push_back(ex[i]);
      tick;
      e = sb.pop_front();
      checks += 3;
      if (pc !== e.pc) begin failures++;
        $display("FAIL jprio pc[%0d]: got %h want %h", i, pc, e.pc); end
      if ({halted, trap, cause} !== e.s) begin failures++;
        $display("FAIL jprio status[%0d]: got %b want %b", i, {halted, trap, cause}, e.s); end
      if (cnt !== e.n) begin failures++;
        $display("FAIL jprio count[%0d]: got %0d want %0d", i, cnt, e.n); end
    end
    checks++;
    if (pc4 !== 32'h44) begin failures++;
      $display("FAIL jprio pc4: got %h want %h", pc4, 32'h44); end
  endtask

  task automatic test_stall;
    stim_t st[6];
    exp_t ex[6];
    exp_t e;
    do_reset;
    st = '{S(0, 0, 0, 0, 0), S(0, 0, 0, 0, 0), S(1, 1, 32'h10, 0, 0),
           S(1, 1, 32'h10, 0, 0), S(1, 1, 32'h10, 0, 0),
           S(0, 1, 32'h10, 0, 0)};
    ex = '{E(32'h0, 1, S_OK, 0), E(32'h4, 1, S_OK, 1),
           E(32'h4, 1, S_OK, 1), E(32'h4, 1, S_OK, 1),
           E(32'h4, 1, S_OK, 1), E(32'h10, 1, S_OK, 2)};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick;
      e = sb.pop_front();
      checks += 3;
      if (pc !== e.pc) begin failures++;
        $display("FAIL stall pc[%0d]: got %h want %h", i, pc, e.pc); end
      if (valid !== e.v) begin failures++;
        $display("FAIL stall valid[%0d]: got %b want %b", i, valid, e.v); end
      if (cnt !== e.n) begin failures++;
        $display("FAIL stall count[%0d]: got %0d want %0d", i, cnt, e.n); end
    end
  endtask

  task automatic test_ebreak;
    stim_t st[7];
    exp_t ex[7];
    exp_t e;
    do_reset;
    eb_pc = 32'hC;
    eb_en = 1'b1;
    st = '{S(0, 0, 0, 0, 0), S(0, 0, 0, 0, 0), S(0, 0, 0, 0, 0),
           S(0, 0, 0, 0, 0), S(0, 0, 0, 0, 0), S(0, 0, 0, 1, 32'h40),
           S(0, 1, 32'h8, 0, 0)};
    ex = '{E(32'h0, 1, S_OK, 0), E(32'h4, 1, S_OK, 1),
           E(32'h8, 1, S_OK, 2), E(32'hC, 1, S_OK, 3),
           E(32'hC, 0, S_EBK, 3), E(32'hC, 0, S_EBK, 3),
           E(32'hC, 0, S_EBK, 3)};
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick;
      e = sb.pop_front();
      checks += 5;
      if (pc !== e.pc) begin failures++;
        $display("FAIL ebrk pc[%0d]: got %h want %h", i, pc, e.pc); end
      if (valid !== e.v) begin failures++;
        $display("FAIL ebrk valid[%0d]: got %b want %b", i, valid, e.v); end
      if ({halted, trap, cause} !== e.s) begin failures++;
        $display("FAIL ebrk status[%0d]: got %b want %b", i, {halted, trap, cause}, e.s); end
      if (cnt !== e.n) begin failures++;
        $display("FAIL ebrk count[%0d]: got %0d want %0d", i, cnt, e.n); end
      if (instr_o !== (e.v ? EBRK : NOP) && i >= 3) begin failures++;
        $display("FAIL ebrk instr[%0d]: got %h want %h", i, instr_o, e.v ? EBRK : NOP); end
    end
    rst = 1'b1;
    tick;
    checks += 2;
    if (pc !== 32'h0) begin failures++;
      $display("FAIL ebrk rst pc: got %h want %h", pc, 32'h0); end
    if ({halted, trap, cause} !== S_OK) begin failures++;
      $display("FAIL ebrk rst status: got %b want %b", {halted, trap, cause}, S_OK); end
    rst = 1'b0;
    eb_en = 1'b0;
  endtask

  task automatic test_out_of_range;
    stim_t st[4];
    exp_t ex[4];
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      do_reset;
      if (r == 0) begin
        st = '{S(0, 0, 0, 0, 0), S(0, 0, 0, 1, 32'h74),
               S(0, 0, 0, 0, 0), S(0, 0, 0, 0, 0)};
        ex = '{E(32'h0, 1, S_OK, 0), E(32'h74, 1, S_OK, 1),
               E(32'h74, 0, S_OOR, 2), E(32'h74, 0, S_OOR, 2)};
      end else begin
        st = '{S(0, 0, 0, 0, 0), S(0, 0, 0, 1, 32'hFFFF_FFFC),
               S(0, 0, 0, 0, 0), S(0, 1, 32'h4, 0, 0)};
        ex = '{E(32'h0, 1, S_OK, 0), E(32'h0, 0, S_OOR, 1),
               E(32'h0, 0, S_OOR, 1), E(32'h0, 0, S_OOR, 1)};
      end
      for (int i = 0; i < 4; i++) begin
        apply(st[i]);
        sb.push_back(ex[i]);
        tick;
        e = sb.pop_front();
        checks += 4;
        if (pc !== e.pc) begin failures++;
          $display("FAIL oor%0d pc[%0d]: got %h want %h", r, i, pc, e.pc); end
        if (valid !== e.v) begin failures++;
          $display("FAIL oor%0d valid[%0d]: got %b want %b", r, i, valid, e.v); end
        if ({halted, trap, cause} !== e.s) begin failures++;
          $display("FAIL oor%0d status[%0d]: got %b want %b", r, i, {halted, trap, cause}, e.s); end
        if (cnt !== e.n) begin failures++;
          $display("FAIL oor%0d count[%0d]: got %0d want %0d", r, i, cnt, e.n); end
      end
    end
  endtask

  task automatic test_misalign;
    stim_t st[3];
    exp_t ex[3];
    exp_t e;
    do_reset;
    st = '{S(0, 0, 0, 0, 0), S(0, 0, 0, 1, 32'h22), S(0, 1, 32'h37, 0, 0)};
`ifdef FETCH_MISALIGN_TRAP_EN
    ex = '{E(32'h0, 1, S_OK, 0), E(32'h0, 0, S_MIS, 1),
           E(32'h0, 0, S_MIS, 1)};
`else
    ex = '{E(32'h0, 1, S_OK, 0), E(32'h20, 1, S_OK, 1),
           E(32'h34, 1, S_OK, 2)};
`endif
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick;
      e = sb.pop_front();
      checks += 4;
      if (pc !== e.pc) begin failures++;
        $display("FAIL mis pc[%0d]: got %h want %h", i, pc, e.pc); end
      if (valid !== e.v) begin failures++;
        $display("FAIL mis valid[%0d]: got %b want %b", i, valid, e.v); end
      if ({halted, trap, cause} !== e.s) begin failures++;
        $display("FAIL mis status[%0d]: got %b want %b", i, {halted, trap, cause}, e.s); end
      if (cnt !== e.n) begin failures++;
        $display("FAIL mis count[%0d]: got %0d want %0d", i, cnt, e.n); end
    end
  endtask

  task automatic test_back_to_back;
    stim_t st[5];
    exp_t ex[5];
    exp_t e;
    do_reset;
    st = '{S(0, 0, 0, 0, 0), S(0, 1, 32'h30, 0, 0), S(0, 0, 0, 1, 32'h8),
           S(0, 1, 32'h1C, 0, 32'h50), S(0, 0, 0, 0, 0)};
    ex = '{E(32'h0, 1, S_OK, 0), E(32'h30, 1, S_OK, 1),
           E(32'h8, 1, S_OK, 2), E(32'h1C, 1, S_OK, 3),
           E(32'h20, 1, S_OK, 4)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick;
      e = sb.pop_front();
      checks += 2;
      if (pc !== e.pc) begin failures++;
        $display("FAIL b2b pc[%0d]: got %h want %h", i, pc, e.pc); end
      if (cnt !== e.n) begin failures++;
        $display("FAIL b2b count[%0d]: got %0d want %0d", i, cnt, e.n); end
    end
  endtask

  task automatic test_reset_priority;
    do_reset;
    for (int i = 0; i < 3; i++) tick;
    rst = 1'b1;
    apply(S(1, 1, 32'h10, 1, 32'h40));
    tick;
    checks += 3;
    if (pc !== 32'h0) begin failures++;
      $display("FAIL rstp pc: got %h want %h", pc, 32'h0); end
    if (valid !== 1'b0) begin failures++;
      $display("FAIL rstp valid: got %b want %b", valid, 1'b0); end
    if (cnt !== 32'd0) begin failures++;
      $display("FAIL rstp count: got %0d want %0d", cnt, 0); end
    rst = 1'b0;
    apply(S(0, 0, 0, 0, 0));
    tick;
    checks += 2;
    if (valid !== 1'b1 || pc !== 32'h0) begin failures++;
      $display("FAIL rstp run: got pc=%h v=%b want pc=0 v=1", pc, valid); end
    if (cnt !== 32'd0) begin failures++;
      $display("FAIL rstp run count: got %0d want %0d", cnt, 0); end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_jump_priority;
    test_stall;
    test_ebreak;
    test_out_of_range;
    test_misalign;
    test_back_to_back;
    test_reset_priority;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
